// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Winning operands are registered onto the ALU, settled for ALU_LAT cycles, then returned on a tagged response.
module alu_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 5,
    parameter int ALU_LAT = 1,   // legal range 1..15
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r0_cin,
    input  logic [OPW-1:0]   r0_op,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic             r1_cin,
    input  logic [OPW-1:0]   r1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_z,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             busy,
    output logic [CNT_W-1:0] r0_count,
    output logic [CNT_W-1:0] r1_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

    state_t     state, state_nxt;
    logic       last_gnt;   // requester granted most recently
    logic       cur_id;
    logic [3:0] wcnt;
    logic       gnt_id, hs, cap, acc;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_id   = (r0_valid && r1_valid) ? ~last_gnt : r1_valid;
        hs       = (state == IDLE) && (r0_valid || r1_valid);
        r0_ready = hs && !gnt_id;
        r1_ready = hs && gnt_id;
        cap      = (state == EXEC) && (wcnt == 4'd0);
        acc      = (state == RESP) && rsp_ready;
        busy     = (state != IDLE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs)  state_nxt = EXEC;
            EXEC:    if (cap) state_nxt = RESP;
            RESP:    if (acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= 1'b1;
            cur_id     <= 1'b0;
            wcnt       <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_opcode <= '0;
        end else if (hs) begin
            last_gnt   <= gnt_id;
            cur_id     <= gnt_id;
            wcnt       <= WAIT_INIT;
            alu_a      <= gnt_id ? r1_a   : r0_a;
            alu_b      <= gnt_id ? r1_b   : r0_b;
            alu_cin    <= gnt_id ? r1_cin : r0_cin;
            alu_opcode <= gnt_id ? r1_op  : r0_op;
        end else if (state == EXEC && wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
        end
    end

    // Response holding register; contents stay frozen for the whole RESP stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_v      <= 1'b0;
            r0_count   <= '0;
            r1_count   <= '0;
        end else if (cap) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= cur_id;
            rsp_result <= alu_result;
            rsp_cout   <= alu_cout;
            rsp_z      <= alu_z;
            rsp_v      <= alu_v;
        end else if (acc) begin
            rsp_valid <= 1'b0;
            if (rsp_id) r1_count <= r1_count + CNT_W'(1);
            else        r0_count <= r0_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench: stub ALU on an ALU_LAT=1 instance checked by a response scoreboard,
// plus an ALU_LAT=3 instance for capture-timing checks.
module tb_alu_rr_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic       co;
        logic       z;
        logic       v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       r0_valid, r0_ready, r0_cin, r1_valid, r1_ready, r1_cin;
    logic [7:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_result, rsp_result;
    logic [4:0] r0_op, r1_op, alu_opcode;
    logic       alu_cin, alu_cout, alu_z, alu_v;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_z, rsp_v, busy;
    logic [15:0] r0_count, r1_count;

    logic       l3_r0_valid, l3_r0_ready, l3_r1_ready, l3_rsp_valid, l3_rsp_id;
    logic       l3_alu_cin, l3_rsp_cout, l3_rsp_z, l3_rsp_v, l3_busy;
    logic [7:0] l3_r0_a, l3_alu_a, l3_alu_b, l3_alu_result, l3_rsp_result;
    logic [4:0] l3_alu_opcode;
    logic [15:0] l3_r0_count, l3_r1_count;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    alu_rr_arbiter #(.WIDTH(8), .OPW(5), .ALU_LAT(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_cin(r0_cin), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_cin(r1_cin), .r1_op(r1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_z(alu_z), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_z(rsp_z), .rsp_v(rsp_v), .busy(busy),
        .r0_count(r0_count), .r1_count(r1_count)
    );

    alu_rr_arbiter #(.WIDTH(8), .OPW(5), .ALU_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(l3_r0_valid), .r0_ready(l3_r0_ready), .r0_a(l3_r0_a), .r0_b(8'h00), .r0_cin(1'b0), .r0_op(5'd0),
        .r1_valid(1'b0), .r1_ready(l3_r1_ready), .r1_a(8'h00), .r1_b(8'h00), .r1_cin(1'b0), .r1_op(5'd0),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_cin(l3_alu_cin), .alu_opcode(l3_alu_opcode),
        .alu_result(l3_alu_result), .alu_cout(1'b0), .alu_z(1'b0), .alu_v(1'b0),
        .rsp_valid(l3_rsp_valid), .rsp_ready(1'b1), .rsp_id(l3_rsp_id), .rsp_result(l3_rsp_result),
        .rsp_cout(l3_rsp_cout), .rsp_z(l3_rsp_z), .rsp_v(l3_rsp_v), .busy(l3_busy),
        .r0_count(l3_r0_count), .r1_count(l3_r1_count)
    );

    // Stub ALU: op0 add with carry, op1 AND, op2 XOR
    logic [8:0] sum;
    always_comb begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_result = 8'h00;
        alu_cout   = 1'b0;
        alu_v      = 1'b0;
        case (alu_opcode)
            5'd0: begin
                alu_result = sum[7:0];
                alu_cout   = sum[8];
                alu_v      = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
            end
            5'd1: alu_result = alu_a & alu_b;
            5'd2: alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h00;
        endcase
        alu_z = (alu_result == 8'h00);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted response must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d result=%0h expected no response", rsp_id, rsp_result);
            end else begin
                e = sbq.pop_front();
                checks--;
                chk("rsp", 64'({rsp_id, rsp_result, rsp_cout, rsp_z, rsp_v}), 64'(e));
            end
        end
    end

    task automatic wait_rdy(input logic id);
        int n = 0;
        @(negedge clk);
        while (!(id ? r1_ready : r0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(id ? "r1_ready" : "r0_ready", 64'(id ? r1_ready : r0_ready), 64'd1);
    endtask

    task automatic wait_rsp();
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_wait", 64'(rsp_valid), 64'd1);
    endtask

    task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [4:0] op);
        @(posedge clk);
        #1 r0_valid = 1'b1; r0_a = a; r0_b = b; r0_cin = cin; r0_op = op;
        wait_rdy(1'b0);
        @(posedge clk);
        #1 r0_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        int  n;
        logic seen;
        rst_n = 1'b0; rsp_ready = 1'b0;
        r0_valid = 0; r0_a = 0; r0_b = 0; r0_cin = 0; r0_op = 0;
        r1_valid = 0; r1_a = 0; r1_b = 0; r1_cin = 0; r1_op = 0;
        l3_r0_valid = 0; l3_r0_a = 0; l3_alu_result = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 64'({rsp_valid, busy, rsp_id, rsp_cout, rsp_z, rsp_v, r0_ready, r1_ready}), 64'd0);
        chk("rst_data", 64'({alu_a, alu_b, alu_opcode, alu_cin, rsp_result}), 64'd0);
        chk("rst_cnt", 64'({r0_count, r1_count}), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Single op: DB + 6D + 1 = 0x149
        rsp_ready = 1'b1;
        sbq.push_back('{id: 1'b0, res: 8'h49, co: 1'b1, z: 1'b0, v: 1'b0});
        @(posedge clk);
        #1 r0_valid = 1'b1; r0_a = 8'hDB; r0_b = 8'h6D; r0_cin = 1'b1; r0_op = 5'd0;
        @(negedge clk) chk("single_rdy", 64'({r0_ready, r1_ready}), 64'b10);
        @(posedge clk);
        #1 r0_valid = 1'b0;
        @(negedge clk) chk("single_alu", 64'({alu_a, alu_b, alu_cin, alu_opcode, busy, rsp_valid}),
                           64'({8'hDB, 8'h6D, 1'b1, 5'd0, 1'b1, 1'b0}));
        @(negedge clk) chk("single_lat", 64'(rsp_valid), 64'd1);
        @(negedge clk) chk("single_cnt", 64'({r0_count, r1_count, rsp_valid}), 64'({16'd1, 16'd0, 1'b0}));

        // Tie after reset: r0 = 7F+01 -> 80 (v), r1 = FF+01 -> 00 (cout, z)
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            sbq.push_back('{id: 1'b0, res: 8'h80, co: 1'b0, z: 1'b0, v: 1'b1});
            sbq.push_back('{id: 1'b1, res: 8'h00, co: 1'b1, z: 1'b1, v: 1'b0});
        end
        r0_a = 8'h7F; r0_b = 8'h01; r0_cin = 1'b0; r0_op = 5'd0;
        r1_a = 8'hFF; r1_b = 8'h01; r1_cin = 1'b0; r1_op = 5'd0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        n = 0;
        while ((r0_count + r1_count) != 16'd6 && n < 60) begin
            @(negedge clk);
            n++;
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        chk("tie_cnt", 64'({r0_count, r1_count}), 64'({16'd3, 16'd3}));
        chk("tie_sb_empty", 64'(sbq.size()), 64'd0);

        // Backpressure: A5 ^ FF = 5A held for 10 cycles
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        sbq.push_back('{id: 1'b0, res: 8'h5A, co: 1'b0, z: 1'b0, v: 1'b0});
        issue0(8'hA5, 8'hFF, 1'b0, 5'd2);
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", 64'({rsp_valid, rsp_result, r0_ready, r1_ready, busy, r0_count}),
                64'({1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 16'd3}));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_release", 64'({r0_count, rsp_valid, busy}), 64'({16'd4, 1'b0, 1'b0}));

        // Withdrawn r1 request during RESP: 80+80 -> 00 with cout, z, v
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        sbq.push_back('{id: 1'b0, res: 8'h00, co: 1'b1, z: 1'b1, v: 1'b1});
        issue0(8'h80, 8'h80, 1'b0, 5'd0);
        wait_rsp();
        @(posedge clk);
        #1 r1_valid = 1'b1; r1_a = 8'h11; r1_b = 8'h22;
        @(negedge clk) chk("wd_no_rdy", 64'({r0_ready, r1_ready}), 64'd0);
        @(posedge clk);
        #1 r1_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("wd_cnt", 64'({r0_count, r1_count, busy, rsp_valid}), 64'({16'd5, 16'd3, 1'b0, 1'b0}));

        // Reset while in EXEC
        @(posedge clk);
        #1 r0_valid = 1'b1; r0_a = 8'hDB; r0_b = 8'h6D; r0_cin = 1'b1; r0_op = 5'd0;
        wait_rdy(1'b0);
        @(posedge clk);
        #1 r0_valid = 1'b0;
        #1 chk("mid_exec", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst", 64'({busy, rsp_valid, alu_a, alu_b, alu_cin, r0_count, r1_count}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) @(negedge clk) seen = seen | rsp_valid | busy;
        chk("mid_quiet", 64'(seen), 64'd0);
        sbq.push_back('{id: 1'b0, res: 8'h80, co: 1'b0, z: 1'b0, v: 1'b1});
        @(posedge clk);
        #1 r0_valid = 1'b1; r0_a = 8'h7F; r0_b = 8'h01; r0_cin = 1'b0;
        r1_valid = 1'b1; r1_a = 8'hFF; r1_b = 8'h01; r1_cin = 1'b0;
        @(negedge clk) chk("mid_tie_rdy", 64'({r0_ready, r1_ready}), 64'b10);
        @(posedge clk);
        #1 r0_valid = 1'b0; r1_valid = 1'b0;
        wait_rsp();
        @(negedge clk) chk("mid_cnt", 64'({r0_count, r1_count}), 64'({16'd1, 16'd0}));

        // ALU_LAT=3: result is 11 at H+1, settles to 3C at H+2, changes to EE after capture
        @(posedge clk);
        #1 l3_r0_valid = 1'b1; l3_r0_a = 8'h3C;
        n = 0;
        @(negedge clk);
        while (!l3_r0_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("l3_ready", 64'(l3_r0_ready), 64'd1);
        @(posedge clk);
        #1 l3_r0_valid = 1'b0;
        @(negedge clk) chk("l3_c0", 64'(l3_rsp_valid), 64'd0);
        @(posedge clk);
        #1 l3_alu_result = 8'h11;
        @(negedge clk) chk("l3_c1", 64'(l3_rsp_valid), 64'd0);
        @(posedge clk);
        #1 l3_alu_result = 8'h3C;
        @(negedge clk) chk("l3_c2", 64'(l3_rsp_valid), 64'd0);
        @(posedge clk);
        #1 l3_alu_result = 8'hEE;
        @(negedge clk) chk("l3_c3", 64'({l3_rsp_valid, l3_rsp_id, l3_rsp_result}), 64'({1'b1, 1'b0, 8'h3C}));
        @(negedge clk) chk("l3_cnt", 64'({l3_rsp_valid, l3_r0_count}), 64'({1'b0, 16'd1}));

        @(negedge clk) chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
